// File: rtl/gf_pkg.sv
// Shared GF(2^M) helpers for the Reed-Solomon arithmetic engine.
// Holds default field polynomials and a width-masked carry-less multiply.
package gf_pkg;

   localparam int GF_MAX_M = 16;
   localparam int GF_ZW    = 2 * GF_MAX_M - 1;

   localparam logic [4:0] GF4_POLY = 5'h13;
   localparam logic [8:0] GF8_POLY = 9'h11D;

   // Carry-less product of the low m bits of a and b.
   // Bits of a and b at or above m are ignored.
   function automatic logic [GF_ZW-1:0] gf_clmul(
      input logic [GF_MAX_M-1:0] a,
      input logic [GF_MAX_M-1:0] b,
      input int                  m
   );
      logic [GF_ZW-1:0] z;
      logic [GF_ZW-1:0] am;
      z  = '0;
      am = '0;
      for (int i = 0; i < GF_MAX_M; i++) begin
         if (i < m) am[i] = a[i];
      end
      for (int i = 0; i < GF_MAX_M; i++) begin
         if ((i < m) && b[i]) z = z ^ (am << i);
      end
      return z;
   endfunction

endpackage

// File: rtl/gf_reduce.sv
// Combinational reduction of a 2M-1 bit carry-less product modulo POLY.
// Ports: i_z (2M-1 bit product), o_p (M bit field element).
module gf_reduce
   import gf_pkg::*;
#(
   parameter int         M    = 8,
   parameter logic [M:0] POLY = 9'h11D
) (
   input  logic [2*M-2:0] i_z,
   output logic [M-1:0]   o_p
);

   localparam logic [2*M-2:0] POLY_EXT = (2*M-1)'(POLY);

   logic [2*M-2:0] w_r;

   // MSB first: each cleared top bit may set lower ones.
   always_comb begin
      w_r = i_z;
      for (int k = 2*M-2; k >= M; k--) begin
         if (w_r[k]) w_r = w_r ^ (POLY_EXT << (k - M));
      end
      o_p = w_r[M-1:0];
   end

endmodule

// File: rtl/gf_mac_pipe.sv
// Pipelined GF(2^M) multiplier with XOR multiply-accumulate mode.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_a/in_b/
// in_mac/in_last input beat; out_valid/out_ready/out_x/out_last result;
// acc_open flags a partial MAC sum held in the accumulator.
module gf_mac_pipe
   import gf_pkg::*;
#(
   parameter int         M      = 8,
   parameter logic [M:0] POLY   = 9'h11D,
   parameter int         STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [M-1:0] in_a,
   input  logic [M-1:0] in_b,
   input  logic         in_mac,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] out_x,
   output logic         out_last,
   output logic         acc_open
);

   localparam int ZW = 2 * M - 1;

   if ((M < 2) || (M > GF_MAX_M)) begin : g_bad_m
      $error("gf_mac_pipe: M out of range 2..16");
   end
   if (POLY[M] != 1'b1) begin : g_bad_poly
      $error("gf_mac_pipe: POLY[M] must be 1");
   end
   if ((STAGES != 1) && (STAGES != 2)) begin : g_bad_stages
      $error("gf_mac_pipe: STAGES must be 1 or 2");
   end

   logic              w_advance;
   logic [GF_ZW-1:0]  w_zfull;
   logic [ZW-1:0]     w_z;
   logic              w_unused;
   logic              w_fv;
   logic              w_fmac;
   logic              w_flast;
   logic [ZW-1:0]     w_fz;
   logic [M-1:0]      w_p;

   logic              r_out_valid;
   logic [M-1:0]      r_out_x;
   logic              r_out_last;
   logic [M-1:0]      r_acc;
   logic              r_acc_open;

   // Whole pipeline freezes while a result waits downstream.
   // out_ready -> in_ready is deliberately combinational.
   assign w_advance = !r_out_valid || out_ready;
   assign in_ready  = w_advance;

   assign w_zfull  = gf_clmul(GF_MAX_M'(in_a), GF_MAX_M'(in_b), M);
   assign w_z      = w_zfull[ZW-1:0];
   assign w_unused = ^(w_zfull >> ZW);

   if (STAGES == 2) begin : g_two
      logic          r_s1_valid;
      logic [ZW-1:0] r_s1_z;
      logic          r_s1_mac;
      logic          r_s1_last;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_z     <= '0;
            r_s1_mac   <= 1'b0;
            r_s1_last  <= 1'b0;
         end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s1_z     <= w_z;
            r_s1_mac   <= in_mac;
            r_s1_last  <= in_last;
         end
      end

      assign w_fv    = r_s1_valid;
      assign w_fz    = r_s1_z;
      assign w_fmac  = r_s1_mac;
      assign w_flast = r_s1_last;
   end else begin : g_one
      assign w_fv    = in_valid;
      assign w_fz    = w_z;
      assign w_fmac  = in_mac;
      assign w_flast = in_last;
   end

   gf_reduce #(
      .M    (M),
      .POLY (POLY)
   ) u_reduce (
      .i_z (w_fz),
      .o_p (w_p)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_x     <= '0;
         r_out_last  <= 1'b0;
         r_acc       <= '0;
         r_acc_open  <= 1'b0;
      end else if (w_advance) begin
         if (!w_fv) begin
            r_out_valid <= 1'b0;
         end else if (!w_fmac) begin
            r_out_x     <= w_p;
            r_out_last  <= w_flast;
            r_out_valid <= 1'b1;
         end else if (!w_flast) begin
            r_acc       <= r_acc ^ w_p;
            r_acc_open  <= 1'b1;
            r_out_valid <= 1'b0;
         end else begin
            r_out_x     <= r_acc ^ w_p;
            r_out_last  <= 1'b1;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_acc_open  <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_x     = r_out_x;
   assign out_last  = r_out_last;
   assign acc_open  = r_acc_open;

endmodule

// File: tb/tb_gf_mac_pipe.sv
// Self-checking bench for gf_mac_pipe: GF(2^8) two-stage and
// GF(2^4) single-stage instances against a shift-and-add field model.
module tb_gf_mac_pipe;

   typedef struct {
      int x;
      int last;
      int cyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   int         cyc;
   int         n_tests;
   int         n_fail;

   logic       v8, ir8, mac8, last8, ov8, ordy8, ol8, ao8;
   logic [7:0] a8, b8, ox8;
   logic       v4, ir4, mac4, last4, ov4, ordy4, ol4, ao4;
   logic [3:0] a4, b4, ox4;

   exp_t       q8[$];
   exp_t       q4[$];
   int         obs8[$];
   int         obs4[$];
   int         acc8, acc4;
   bit         lat8, lat4, rnd8, rnd4;

   gf_mac_pipe #(.M(8), .POLY(9'h11D), .STAGES(2)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8),
      .in_mac(mac8), .in_last(last8),
      .out_valid(ov8), .out_ready(ordy8), .out_x(ox8),
      .out_last(ol8), .acc_open(ao8)
   );

   gf_mac_pipe #(.M(4), .POLY(5'h13), .STAGES(1)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v4), .in_ready(ir4), .in_a(a4), .in_b(b4),
      .in_mac(mac4), .in_last(last4),
      .out_valid(ov4), .out_ready(ordy4), .out_x(ox4),
      .out_last(ol4), .acc_open(ao4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Field multiply by repeated doubling: a*x with reduction each step.
   function automatic int gf_mul(int a, int b, int m, int poly);
      int r;
      r = 0;
      for (int i = 0; i < m; i++) begin
         if (((b >> i) & 1) != 0) r = r ^ a;
         a = a << 1;
         if ((a & (1 << m)) != 0) a = a ^ poly;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      #1;
      if (rnd8) ordy8 = ($urandom_range(0, 3) != 0);
      if (rnd4) ordy4 = ($urandom_range(0, 3) != 0);
   end

   always @(negedge clk) begin
      exp_t e;
      int   p;
      if (!rst_n) begin
         q8.delete();
         acc8 = 0;
      end else begin
         check("in_ready8", ir8, int'(!ov8 || ordy8));
         if (ov8 && ordy8) begin
            if (q8.size() == 0) begin
               check("spurious8", 1, q8.size());
            end else begin
               e = q8.pop_front();
               obs8.push_back(int'(ox8));
               check("x8", ox8, e.x);
               check("last8", ol8, e.last);
               if (lat8) check("lat8", cyc - e.cyc, 2);
            end
         end
         if (v8 && ir8) begin
            p = gf_mul(a8, b8, 8, 'h11D);
            if (!mac8) begin
               q8.push_back('{p, int'(last8), cyc});
            end else if (!last8) begin
               acc8 = acc8 ^ p;
            end else begin
               q8.push_back('{acc8 ^ p, 1, cyc});
               acc8 = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      int   p;
      if (!rst_n) begin
         q4.delete();
         acc4 = 0;
      end else begin
         check("in_ready4", ir4, int'(!ov4 || ordy4));
         if (ov4 && ordy4) begin
            if (q4.size() == 0) begin
               check("spurious4", 1, q4.size());
            end else begin
               e = q4.pop_front();
               obs4.push_back(int'(ox4));
               check("x4", ox4, e.x);
               check("last4", ol4, e.last);
               if (lat4) check("lat4", cyc - e.cyc, 1);
            end
         end
         if (v4 && ir4) begin
            p = gf_mul(a4, b4, 4, 'h13);
            if (!mac4) begin
               q4.push_back('{p, int'(last4), cyc});
            end else if (!last4) begin
               acc4 = acc4 ^ p;
            end else begin
               q4.push_back('{acc4 ^ p, 1, cyc});
               acc4 = 0;
            end
         end
      end
   end

   task automatic send8(input int a, input int b, input int mac, input int last);
      bit ok;
      ok = 0;
      @(posedge clk); #1;
      v8 = 1'b1; a8 = 8'(a); b8 = 8'(b);
      mac8 = 1'(mac); last8 = 1'(last);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (ir8) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      check("send8_accept", ok, 1);
   endtask

   task automatic send4(input int a, input int b, input int mac, input int last);
      bit ok;
      ok = 0;
      @(posedge clk); #1;
      v4 = 1'b1; a4 = 4'(a); b4 = 4'(b);
      mac4 = 1'(mac); last4 = 1'(last);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (ir4) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      check("send4_accept", ok, 1);
   endtask

   task automatic idle8();
      @(posedge clk); #1 v8 = 1'b0;
   endtask

   task automatic idle4();
      @(posedge clk); #1 v4 = 1'b0;
   endtask

   task automatic drain8();
      idle8();
      for (int i = 0; i < 60 && q8.size() != 0; i++) @(negedge clk);
      repeat (3) @(posedge clk);
      check("drain8", q8.size(), 0);
   endtask

   task automatic drain4();
      idle4();
      for (int i = 0; i < 60 && q4.size() != 0; i++) @(negedge clk);
      repeat (3) @(posedge clk);
      check("drain4", q4.size(), 0);
   endtask

   task automatic check_obs8(input string tag, input int idx, input int exp);
      check({tag, "_seen"}, int'(obs8.size() > idx), 1);
      if (obs8.size() > idx) check(tag, obs8[idx], exp);
   endtask

   initial begin
      logic [7:0] hx;
      logic       hl;
      n_tests = 0; n_fail = 0; cyc = 0;
      rst_n = 1'b0;
      v8 = 0; a8 = 0; b8 = 0; mac8 = 0; last8 = 0; ordy8 = 1;
      v4 = 0; a4 = 0; b4 = 0; mac4 = 0; last4 = 0; ordy4 = 1;
      lat8 = 0; lat4 = 0; rnd8 = 0; rnd4 = 0;
      acc8 = 0; acc4 = 0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ov8", ov8, 0);
      check("rst_x8", ox8, 0);
      check("rst_last8", ol8, 0);
      check("rst_open8", ao8, 0);
      check("rst_ir8", ir8, 1);
      check("rst_ov4", ov4, 0);
      #1 rst_n = 1'b1;

      lat8 = 1;
      obs8.delete();
      send8('h03, 'h03, 0, 0);
      send8('h02, 'h80, 0, 1);
      send8('h80, 'h80, 0, 0);
      send8('h01, 'hB7, 0, 1);
      send8('h00, 'hFF, 0, 0);
      drain8();
      check_obs8("mul_03x03", 0, 'h05);
      check_obs8("mul_02x80", 1, 'h1D);
      check_obs8("mul_80x80", 2, 'h13);
      check_obs8("mul_01xB7", 3, 'hB7);
      check_obs8("mul_00xFF", 4, 'h00);

      obs8.delete();
      check("open_idle", ao8, 0);
      send8('h02, 'h80, 1, 0);
      idle8();
      @(posedge clk); @(negedge clk);
      check("open_mac1", ao8, 1);
      send8('h03, 'h03, 1, 0);
      send8('h80, 'h80, 1, 1);
      drain8();
      check("open_closed", ao8, 0);
      check_obs8("mac_sum", 0, 'h0B);
      check("mac_count", obs8.size(), 1);

      obs8.delete();
      send8('h03, 'h03, 1, 1);
      drain8();
      check_obs8("mac_single", 0, 'h05);

      obs8.delete();
      send8('h02, 'h80, 1, 0);
      send8('h03, 'h03, 0, 0);
      send8('h80, 'h80, 1, 1);
      drain8();
      check_obs8("ilv_mul", 0, 'h05);
      check_obs8("ilv_mac", 1, 'h0E);
      lat8 = 0;

      @(posedge clk); #1;
      ordy8 = 0; v8 = 1; mac8 = 0; last8 = 1;
      a8 = 8'($urandom); b8 = 8'($urandom);
      for (int i = 0; i < 10 && !ov8; i++) @(negedge clk);
      check("bp_pending", ov8, 1);
      hx = ox8; hl = ol8;
      repeat (5) begin
         @(posedge clk); #1;
         a8 = 8'($urandom); b8 = 8'($urandom); last8 = 1'($urandom);
         @(negedge clk);
         check("bp_ready", ir8, 0);
         check("bp_x", ox8, hx);
         check("bp_last", ol8, hl);
      end
      @(posedge clk); #1 ordy8 = 1; v8 = 0;
      drain8();

      rnd8 = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0) idle8();
         else send8($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 1), int'($urandom_range(0, 2) == 0));
      end
      rnd8 = 0;
      @(posedge clk); #1 ordy8 = 1;
      drain8();

      lat8 = 1;
      send8('h02, 'h80, 1, 0);
      send8('h03, 'h03, 1, 0);
      idle8();
      @(posedge clk); @(negedge clk);
      check("open_pre_rst", ao8, 1);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      check("mrst_ov8", ov8, 0);
      check("mrst_x8", ox8, 0);
      check("mrst_last8", ol8, 0);
      check("mrst_open8", ao8, 0);
      check("mrst_ir8", ir8, 1);
      #1 rst_n = 1'b1;
      obs8.delete();
      send8('h03, 'h03, 1, 1);
      drain8();
      check_obs8("post_rst_mac", 0, 'h05);
      check("post_rst_open", ao8, 0);

      lat4 = 1;
      obs4.delete();
      send4('h8, 'h2, 0, 0);
      send4('hF, 'hF, 0, 1);
      drain4();
      check("g4_seen", obs4.size(), 2);
      if (obs4.size() == 2) begin
         check("g4_8x2", obs4[0], 'h3);
         check("g4_FxF", obs4[1], 'hA);
      end
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            send4(a, b, 0, $urandom_range(0, 1));
      drain4();
      lat4 = 0;

      rnd4 = 1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 4) == 0) idle4();
         else send4($urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 1), int'($urandom_range(0, 2) == 0));
      end
      rnd4 = 0;
      @(posedge clk); #1 ordy4 = 1;
      drain4();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
